regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter BITSIZE, default 64, SHALL set the write-data width.
REQ-002 Parameter REGSIZE, default 32, SHALL set the register count; select width AW = $clog2(REGSIZE).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 alu_valid  input  1  SHALL mean the ALU writeback request is present.
REQ-006 alu_sel  input  AW  SHALL carry the ALU destination register.
REQ-007 alu_data  input  BITSIZE  SHALL carry the ALU result.
REQ-008 alu_ready  output  1  SHALL mean the ALU request is accepted this cycle.
REQ-009 mem_valid, mem_sel (AW), mem_data (BITSIZE), mem_ready SHALL be the load-writeback requester, with the same meanings as the ALU ports.
REQ-010 reserve_en  input  1  SHALL mean the issue stage claims a destination register.
REQ-011 reserve_sel  input  AW  SHALL carry the claimed register.
REQ-012 WriteEnable  output  1  SHALL be the register-file write strobe (registered).
REQ-013 WriteSelect  output  AW  SHALL be the register-file write index (registered).
REQ-014 WriteData  output  BITSIZE  SHALL be the register-file write data (registered).
REQ-015 busy  output  REGSIZE  SHALL have bit i set while register i has a reserved, unwritten result.

Function
REQ-016 A transfer SHALL occur on a requester when valid and ready are both high at a rising edge.
REQ-017 ready SHALL be combinational from the valid inputs and the priority state; at most one ready SHALL be high per cycle; ready SHALL be low when its valid is low.
REQ-018 If only one requester is valid, it SHALL be granted.
REQ-019 If both are valid, the requester named by the 1-bit priority pointer SHALL be granted; the loser SHALL see ready low and hold its request.
REQ-020 After any grant, the pointer SHALL point to the non-granted requester (round-robin); with no grant it SHALL hold.
REQ-021 A transfer with sel != 0 at edge E SHALL drive WriteEnable=1 with the captured sel/data for exactly the cycle after E, so the register file writes at edge E+1.
REQ-022 A transfer with sel == 0 SHALL be accepted (ready high) but SHALL NOT assert WriteEnable.
REQ-023 With no transfer at edge E, WriteEnable SHALL be 0 after E; WriteSelect/WriteData SHALL hold their last values.
REQ-024 Sustained throughput SHALL be one write per cycle; back-to-back transfers SHALL produce consecutive WriteEnable cycles.
REQ-025 reserve_en=1 with reserve_sel != 0 SHALL set busy[reserve_sel] at the edge; reserve_sel == 0 SHALL be ignored; busy[0] SHALL always be 0.
REQ-026 busy[WriteSelect] SHALL clear at the edge that ends a WriteEnable=1 cycle.
REQ-027 A reserve and a clear of the same register at the same edge SHALL leave the bit set (new producer wins).
REQ-028 Reserving an already-busy register SHALL leave it set (no counting).
REQ-029 Requests SHALL NOT be checked against busy; the arbiter does not stall on the scoreboard.

Reset
REQ-030 While rst=1 at an edge: WriteEnable=0, WriteSelect=0, WriteData=0, busy=0, and pointer=ALU SHALL be set.
REQ-031 While rst=1, alu_ready and mem_ready SHALL be 0, and no transfer or reserve SHALL be taken.
REQ-032 A reset asserted with a write pending on the port SHALL cancel that write: WriteEnable=0 on the following cycle.

Verification
REQ-033 Reset, then alu_valid=1, alu_sel=5, alu_data=0xAA for one cycle -> alu_ready=1; next cycle WriteEnable=1, WriteSelect=5, WriteData=0xAA; the cycle after, WriteEnable=0.
REQ-034 After reset, both valid (alu_sel=1, mem_sel=2) held for 2 cycles -> ALU is granted first, then MEM; WriteSelect=1 then 2 on consecutive cycles.
REQ-035 After REQ-034, both valid again -> ALU is granted (pointer alternates); no requester waits more than one cycle.
REQ-036 mem_valid=1, mem_sel=0 -> mem_ready=1; WriteEnable stays 0; busy is unchanged.
REQ-037 reserve_sel=7 -> busy[7]=1; a write to 7 then gives WriteEnable=1 for one cycle and busy[7]=0 after that edge; reserving 7 on that same edge keeps busy[7]=1.
REQ-038 A transfer at edge E with rst=1 at edge E+1 -> WriteEnable=0 after E+1, busy=0, and pointer=ALU.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: round-robin between ALU and load
// writeback, registered write port, and a busy scoreboard per register.
// Ports: clk, rst (sync, active-high); alu_/mem_ valid/sel/data/ready
// requesters; reserve_en/reserve_sel claim a destination; WriteEnable/
// WriteSelect/WriteData drive the register file; busy[i] marks pending
// results.
module regfile_wb_arbiter #(
   parameter int BITSIZE = 64,
   parameter int REGSIZE = 32,
   localparam int AW = $clog2(REGSIZE)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               alu_valid,
   input  logic [AW-1:0]      alu_sel,
   input  logic [BITSIZE-1:0] alu_data,
   output logic               alu_ready,
   input  logic               mem_valid,
   input  logic [AW-1:0]      mem_sel,
   input  logic [BITSIZE-1:0] mem_data,
   output logic               mem_ready,
   input  logic               reserve_en,
   input  logic [AW-1:0]      reserve_sel,
   output logic               WriteEnable,
   output logic [AW-1:0]      WriteSelect,
   output logic [BITSIZE-1:0] WriteData,
   output logic [REGSIZE-1:0] busy
);

   // prio_q: 0 favours ALU, 1 favours MEM when both request
   logic               prio_q, prio_d;
   logic               we_q, we_d;
   logic [AW-1:0]      wsel_q, wsel_d;
   logic [BITSIZE-1:0] wdata_q, wdata_d;
   logic [REGSIZE-1:0] busy_q, busy_d;

   logic               fire;
   logic [AW-1:0]      g_sel;
   logic [BITSIZE-1:0] g_data;

   always_comb begin
      alu_ready = !rst && alu_valid && (!mem_valid || !prio_q);
      mem_ready = !rst && mem_valid && (!alu_valid || prio_q);
      fire      = alu_ready || mem_ready;
      g_sel     = alu_ready ? alu_sel  : mem_sel;
      g_data    = alu_ready ? alu_data : mem_data;

      prio_d = prio_q;
      if (alu_ready)
         prio_d = 1'b1;
      else if (mem_ready)
         prio_d = 1'b0;

      // register 0 is hardwired; accept the transfer but never write it
      we_d    = fire && (g_sel != '0);
      wsel_d  = fire ? g_sel  : wsel_q;
      wdata_d = fire ? g_data : wdata_q;

      // clear first so a same-edge reserve of that register wins
      busy_d = busy_q;
      if (we_q)
         busy_d[wsel_q] = 1'b0;
      if (reserve_en && (reserve_sel != '0))
         busy_d[reserve_sel] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio_q  <= 1'b0;
         we_q    <= 1'b0;
         wsel_q  <= '0;
         wdata_q <= '0;
         busy_q  <= '0;
      end else begin
         prio_q  <= prio_d;
         we_q    <= we_d;
         wsel_q  <= wsel_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
      end
   end

   assign WriteEnable = we_q;
   assign WriteSelect = wsel_q;
   assign WriteData   = wdata_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios then random
// traffic compared against a transaction-level reference model.
module tb_regfile_wb_arbiter;

   localparam int BITSIZE = 64;
   localparam int REGSIZE = 32;
   localparam int AW = 5;

   logic               clk = 1'b0;
   logic               rst;
   logic               alu_valid, mem_valid, reserve_en;
   logic [AW-1:0]      alu_sel, mem_sel, reserve_sel;
   logic [BITSIZE-1:0] alu_data, mem_data;
   logic               alu_ready, mem_ready;
   logic               WriteEnable;
   logic [AW-1:0]      WriteSelect;
   logic [BITSIZE-1:0] WriteData;
   logic [REGSIZE-1:0] busy;

   int errors = 0;
   int checks = 0;

   // reference model state
   bit                 m_favor_mem;
   logic [REGSIZE-1:0] m_busy;
   bit                 m_we;
   logic [AW-1:0]      m_sel;
   logic [BITSIZE-1:0] m_data;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.BITSIZE(BITSIZE), .REGSIZE(REGSIZE)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_sel(alu_sel),
      .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_sel(mem_sel),
      .mem_data(mem_data), .mem_ready(mem_ready),
      .reserve_en(reserve_en), .reserve_sel(reserve_sel),
      .WriteEnable(WriteEnable), .WriteSelect(WriteSelect),
      .WriteData(WriteData), .busy(busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one clock: drive, check readies, model the edge, check outputs
   task automatic cyc(input bit r,
                      input bit av, input int asel, input logic [63:0] ad,
                      input bit mv, input int msel, input logic [63:0] md,
                      input bit re, input int rsel);
      int winner; // 0 none, 1 alu, 2 mem
      logic [AW-1:0] wsel;
      @(negedge clk);
      rst = r;
      alu_valid = av; alu_sel = AW'(asel); alu_data = ad;
      mem_valid = mv; mem_sel = AW'(msel); mem_data = md;
      reserve_en = re; reserve_sel = AW'(rsel);
      #1;
      if (r) winner = 0;
      else if (av && mv) winner = m_favor_mem ? 2 : 1;
      else if (av) winner = 1;
      else if (mv) winner = 2;
      else winner = 0;
      chk("alu_ready", 64'(alu_ready), 64'(winner == 1));
      chk("mem_ready", 64'(mem_ready), 64'(winner == 2));
      if (r) begin
         m_favor_mem = 0; m_busy = '0; m_we = 0; m_sel = '0; m_data = '0;
      end else begin
         if (m_we) m_busy[m_sel] = 1'b0;
         if (re && rsel != 0) m_busy[rsel] = 1'b1;
         if (winner != 0) begin
            wsel = (winner == 1) ? AW'(asel) : AW'(msel);
            m_we = (wsel != 0);
            m_sel = wsel;
            m_data = (winner == 1) ? ad : md;
            m_favor_mem = (winner == 1);
         end else begin
            m_we = 0;
         end
      end
      @(posedge clk);
      #1;
      chk("WriteEnable", 64'(WriteEnable), 64'(m_we));
      chk("WriteSelect", 64'(WriteSelect), 64'(m_sel));
      chk("WriteData", WriteData, m_data);
      chk("busy", 64'(busy), 64'(m_busy));
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      cyc(1, 1, 3, 64'h11, 1, 4, 64'h22, 1, 9);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1; alu_valid = 0; mem_valid = 0; reserve_en = 0;
      alu_sel = '0; mem_sel = '0; reserve_sel = '0;
      alu_data = '0; mem_data = '0;
      m_favor_mem = 0; m_busy = '0; m_we = 0; m_sel = '0; m_data = '0;

      do_reset();
      chk("rst_we", 64'(WriteEnable), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);

      // single ALU write
      cyc(0, 1, 5, 64'hAA, 0, 0, 0, 0, 0);
      chk("r33_we", 64'(WriteEnable), 64'd1);
      chk("r33_sel", 64'(WriteSelect), 64'd5);
      chk("r33_data", WriteData, 64'hAA);
      idle();
      chk("r33_we_off", 64'(WriteEnable), 64'd0);
      chk("r33_data_hold", WriteData, 64'hAA);

      // contention: ALU, then MEM, then ALU again
      do_reset();
      cyc(0, 1, 1, 64'h101, 1, 2, 64'h202, 0, 0);
      chk("r34_first", 64'(WriteSelect), 64'd1);
      cyc(0, 0, 0, 0, 1, 2, 64'h202, 0, 0);
      chk("r34_second", 64'(WriteSelect), 64'd2);
      chk("r34_b2b", 64'(WriteEnable), 64'd1);
      cyc(0, 1, 6, 64'h606, 1, 8, 64'h808, 0, 0);
      chk("r35_alu", 64'(WriteSelect), 64'd6);
      cyc(0, 0, 0, 0, 1, 8, 64'h808, 0, 0);
      chk("r35_mem", 64'(WriteSelect), 64'd8);

      // write to register 0 is accepted but suppressed
      cyc(0, 0, 0, 0, 1, 0, 64'hDEAD, 0, 0);
      chk("r36_we", 64'(WriteEnable), 64'd0);
      idle();

      // scoreboard set / clear / same-edge reserve
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 7);
      chk("r37_set", 64'(busy[7]), 64'd1);
      cyc(0, 1, 7, 64'h77, 0, 0, 0, 1, 7);
      chk("r37_dup", 64'(busy[7]), 64'd1);
      idle();
      chk("r37_clr", 64'(busy[7]), 64'd0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 7);
      cyc(0, 1, 7, 64'h78, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 7);
      chk("r37_keep", 64'(busy[7]), 64'd1);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("busy0", 64'(busy[0]), 64'd0);

      // reset cancels a pending write and restores ALU priority
      cyc(0, 0, 0, 0, 1, 3, 64'h33, 1, 4);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("r38_we", 64'(WriteEnable), 64'd0);
      chk("r38_busy", 64'(busy), 64'd0);
      cyc(0, 1, 9, 64'h99, 1, 10, 64'hA0, 0, 0);
      chk("r38_ptr", 64'(WriteSelect), 64'd9);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(39) == 0),
             $urandom_range(1), int'($urandom_range(31)),
             {$urandom, $urandom},
             $urandom_range(1), int'($urandom_range(31)),
             {$urandom, $urandom},
             $urandom_range(1), int'($urandom_range(31)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
